drum_error_monitor: RTL and testbench
=====================================

// Module: drum_error_monitor
// PURPOSE
//  Downstream stage of the 8x8 DRUM approximate multiplier (k=4). Takes each operand pair
//  together with the approximate 16-bit product and computes the exact product in a
//  two-stage pipeline. Accumulates error statistics over a programmable window of samples,
//  then holds one report record until the consumer accepts it.
//  Used for on-silicon / testbench characterisation of multiplier accuracy.
// PARAMETERS
//  WINDOW   256  samples per measurement window (>=1)
//  ACC_W    32   width of the error-distance accumulator (>=17)
//  CNT_W    16   width of sample/error counters (must hold WINDOW)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      1-cycle pulse: clear stats, begin a window (honoured in IDLE only)
//  s_valid     in   1      input sample valid
//  s_ready     out  1      input sample ready
//  op_a        in   8      accurate operand 1
//  op_b        in   8      accurate operand 2
//  approx_prod in   16     DRUM product for (op_a, op_b)
//  m_valid     out  1      report valid
//  m_ready     in   1      report accepted
//  sum_ed      out  ACC_W  sum of |exact-approx| over window, saturating at all-ones
//  max_ed      out  16     largest |exact-approx| in window
//  err_cnt     out  CNT_W  samples with approx != exact
//  over_cnt    out  CNT_W  samples with approx > exact
//  busy        out  1      high in ACCUM, DRAIN and REPORT
// BEHAVIOUR
//  Reset: state=IDLE. s_ready, m_valid and busy are 0. sum_ed, max_ed, err_cnt and over_cnt are 0.
//  The pipeline valid bits clear; rst mid-window discards the partial window.
//  A sample is accepted when s_valid&&s_ready. s_ready = (state==ACCUM) && (accepted<WINDOW).
//  Pipe S1 (cycle after accept): register exact=op_a*op_b (16b unsigned) and approx_prod.
//  Pipe S2 (next cycle): ed = |exact-approx| (16b). Update the accumulators:
//    sum_ed += ed, saturating; max_ed = max(max_ed, ed);
//    err_cnt += (ed!=0); over_cnt += (approx>exact).
//  A sample is therefore reflected in the stats 2 cycles after acceptance.
//  FSM:
//    IDLE   --start--> ACCUM. Stats and the accepted counter clear on the same edge.
//    ACCUM  --accepted==WINDOW--> DRAIN.
//    DRAIN  --both pipe stages empty--> REPORT. This takes <=2 cycles.
//    REPORT: m_valid=1 and outputs are stable. --m_ready--> IDLE. Stats are held until the next start.
//  start outside IDLE is ignored. start and rst in the same cycle: rst wins.
//  s_valid outside ACCUM is ignored (s_ready=0). No sample is dropped or double-counted.
//  WINDOW=1: a single accepted sample goes straight ACCUM->DRAIN.
//  m_ready held high: IDLE is reached 1 cycle after m_valid rises. m_valid never drops without m_ready.
//  Saturation: sum_ed sticks at 2^ACC_W-1 once reached; the counters cannot overflow by parameter rule.
// STRUCTURE
//  Shared package drum_pkg: OP_W=8, PROD_W=16, K=4, FSM state enum {IDLE,ACCUM,DRAIN,REPORT}.
//  One natural sub-module: drum_abs_diff (16b |a-b| plus an a>b flag, purely combinational), instanced in S2.
//  FSM, counters and pipe registers stay in this module.
// TESTING
//  1) rst then start; 4 samples (WINDOW=4), approx==exact each (3*5->15) -> report sum_ed=0, max_ed=0, err_cnt=0.
//  2) WINDOW=2; (255,255,approx=57600), (200,100,approx=19200) -> exact 65025/20000.
//     Required report: sum_ed=8225, max_ed=7425, err_cnt=2, over_cnt=0.
//  3) One sample op 10x10 with approx=112 -> over_cnt=1, sum_ed=12.
//  4) Back-pressure: m_ready=0 for 20 cycles in REPORT -> m_valid stays 1, outputs stable, s_ready=0;
//     m_ready=1 -> IDLE next cycle.
//  5) rst asserted after 2 of 4 samples -> all outputs 0, state IDLE. Next start + 4 samples counts only the new 4.
//  6) ACC_W=17, WINDOW=4, four samples with ed=65535 -> sum_ed saturates at 131071. start during ACCUM has no effect.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared definitions for the DRUM (k=4) 8x8 approximate multiplier characterisation path.
// Contents:
//   OP_W    operand width of the multiplier
//   PROD_W  product width (exact and approximate)
//   K       DRUM truncation width the approximate products come from
//   state_e report-window FSM states
package drum_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int K      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_e;

endpackage

// File: rtl/drum_abs_diff.sv
// Unsigned absolute difference of two products, plus a flag telling which one is larger.
// Purely combinational.
// Ports:
//   a_i       first product (the approximate one in the monitor)
//   b_i       second product (the exact one in the monitor)
//   diff_o    |a_i - b_i|
//   a_gt_b_o  1 when a_i > b_i
module drum_abs_diff
    import drum_pkg::*;
(
    input  logic [PROD_W-1:0] a_i,
    input  logic [PROD_W-1:0] b_i,
    output logic [PROD_W-1:0] diff_o,
    output logic              a_gt_b_o
);

    always_comb begin
        a_gt_b_o = (a_i > b_i);
        diff_o   = a_gt_b_o ? (a_i - b_i) : (b_i - a_i);
    end

endmodule

// File: rtl/drum_error_monitor.sv
// Error-statistics monitor behind the DRUM approximate multiplier.
// Each accepted sample (op_a, op_b, approx_prod) has its exact product formed in stage 1
// and its error distance folded into the window statistics in stage 2. After WINDOW
// samples the pipe drains and one report record is held until the consumer takes it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a new window (only looked at in IDLE)
//   s_valid / s_ready   sample handshake; op_a, op_b, approx_prod carry the sample
//   m_valid / m_ready   report handshake
//   sum_ed              saturating sum of |exact-approx|
//   max_ed              largest |exact-approx|
//   err_cnt             samples with approx != exact
//   over_cnt            samples with approx > exact
//   busy                window in progress or report pending
module drum_error_monitor
    import drum_pkg::*;
#(
    parameter int WINDOW = 256,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    input  logic [PROD_W-1:0] approx_prod,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  sum_ed,
    output logic [PROD_W-1:0] max_ed,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  over_cnt,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    // Adds one error distance to the running sum, sticking at all-ones on overflow.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [PROD_W-1:0] inc);
        logic [ACC_W:0] full;
        full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, inc};
        return full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic                clr_stats;
    logic                accept;

    logic                vld_p1_q;
    logic [PROD_W-1:0]   exact_p1_q;
    logic [PROD_W-1:0]   approx_p1_q;

    logic [PROD_W-1:0]   ed_p2;
    logic                over_p2;

    logic [ACC_W-1:0]    sum_q, sum_d;
    logic [PROD_W-1:0]   max_q, max_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [CNT_W-1:0]    over_q, over_d;

    assign s_ready = (state_q == ACCUM) && (acc_cnt_q < WIN_C);
    assign accept  = s_valid && s_ready;
    assign m_valid = (state_q == REPORT);
    assign busy    = (state_q != IDLE);

    assign sum_ed   = sum_q;
    assign max_ed   = max_q;
    assign err_cnt  = err_q;
    assign over_cnt = over_q;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        clr_stats = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    acc_cnt_d = '0;
                    clr_stats = 1'b1;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                    // The counter reaches WINDOW on this edge, so leave ACCUM together with it.
                    if (acc_cnt_q == WIN_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Stage 2 is the stats register itself, so an empty stage 1 means nothing is in flight.
                if (!vld_p1_q) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    // ---------------- Stage 1: exact product ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            exact_p1_q  <= {{(PROD_W - OP_W){1'b0}}, op_a} * {{(PROD_W - OP_W){1'b0}}, op_b};
            approx_p1_q <= approx_prod;
        end
    end

    // ---------------- Stage 2: error distance and statistics ----------------
    drum_abs_diff u_abs_diff (
        .a_i      (approx_p1_q),
        .b_i      (exact_p1_q),
        .diff_o   (ed_p2),
        .a_gt_b_o (over_p2)
    );

    always_comb begin
        sum_d  = sum_q;
        max_d  = max_q;
        err_d  = err_q;
        over_d = over_q;
        if (clr_stats) begin
            sum_d  = '0;
            max_d  = '0;
            err_d  = '0;
            over_d = '0;
        end else if (vld_p1_q) begin
            sum_d  = sat_add(sum_q, ed_p2);
            max_d  = (ed_p2 > max_q) ? ed_p2 : max_q;
            err_d  = err_q + {{(CNT_W - 1){1'b0}}, (ed_p2 != '0)};
            over_d = over_q + {{(CNT_W - 1){1'b0}}, over_p2};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            max_q  <= '0;
            err_q  <= '0;
            over_q <= '0;
        end else begin
            sum_q  <= sum_d;
            max_q  <= max_d;
            err_q  <= err_d;
            over_q <= over_d;
        end
    end

endmodule

// File: tb/tb_drum_error_monitor.sv
// Bench for drum_error_monitor. Three instances: WINDOW=4 with a 32-bit sum, WINDOW=4 with a
// 17-bit sum (sharing all inputs with the first), and WINDOW=1 with its own start/m_ready.
module tb_drum_error_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start1, s_valid, m_ready, m_ready1;
    logic [7:0]  op_a, op_b;
    logic [15:0] approx_prod;

    logic        s_ready0, m_valid0, busy0;
    logic [31:0] sum0;
    logic [15:0] max0, err0, over0;

    logic        s_readys, m_valids, busys;
    logic [16:0] sums;
    logic [15:0] maxs, errs, overs;

    logic        s_ready1, m_valid1, busy1;
    logic [31:0] sum1;
    logic [15:0] max1, err1, over1;

    drum_error_monitor #(.WINDOW(4), .ACC_W(32), .CNT_W(16)) u_w4 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready0),
        .op_a(op_a), .op_b(op_b), .approx_prod(approx_prod), .m_valid(m_valid0),
        .m_ready(m_ready), .sum_ed(sum0), .max_ed(max0), .err_cnt(err0),
        .over_cnt(over0), .busy(busy0)
    );

    drum_error_monitor #(.WINDOW(4), .ACC_W(17), .CNT_W(16)) u_sat (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_readys),
        .op_a(op_a), .op_b(op_b), .approx_prod(approx_prod), .m_valid(m_valids),
        .m_ready(m_ready), .sum_ed(sums), .max_ed(maxs), .err_cnt(errs),
        .over_cnt(overs), .busy(busys)
    );

    drum_error_monitor #(.WINDOW(1), .ACC_W(32), .CNT_W(16)) u_w1 (
        .clk(clk), .rst(rst), .start(start1), .s_valid(s_valid), .s_ready(s_ready1),
        .op_a(op_a), .op_b(op_b), .approx_prod(approx_prod), .m_valid(m_valid1),
        .m_ready(m_ready1), .sum_ed(sum1), .max_ed(max1), .err_cnt(err1),
        .over_cnt(over1), .busy(busy1)
    );

    typedef struct {
        int a;
        int b;
        int ap;
    } smp_t;

    smp_t win_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window statistics straight from the definitions, with the sum clipped to ACC_W bits.
    task automatic model(input int acc_w, output longint e_sum, output longint e_max,
                         output longint e_err, output longint e_over);
        longint lim, ex, ed;
        lim = (longint'(1) << acc_w) - 1;
        e_sum = 0; e_max = 0; e_err = 0; e_over = 0;
        foreach (win_q[i]) begin
            ex = longint'(win_q[i].a) * longint'(win_q[i].b);
            ed = (win_q[i].ap > ex) ? (win_q[i].ap - ex) : (ex - win_q[i].ap);
            e_sum += ed;
            if (ed > e_max) e_max = ed;
            if (ed != 0) e_err++;
            if (win_q[i].ap > ex) e_over++;
        end
        if (e_sum > lim) e_sum = lim;
    endtask

    task automatic check_stats(input int sel, input string tag);
        longint es, em, ee, eo;
        model(32, es, em, ee, eo);
        if (sel == 1) begin
            check_val({tag, "/w1_sum"}, sum1, es);
            check_val({tag, "/w1_max"}, max1, em);
            check_val({tag, "/w1_err"}, err1, ee);
            check_val({tag, "/w1_over"}, over1, eo);
        end else begin
            check_val({tag, "/sum"}, sum0, es);
            check_val({tag, "/max"}, max0, em);
            check_val({tag, "/err"}, err0, ee);
            check_val({tag, "/over"}, over0, eo);
            model(17, es, em, ee, eo);
            check_val({tag, "/sat_sum"}, sums, es);
            check_val({tag, "/sat_max"}, maxs, em);
            check_val({tag, "/sat_err"}, errs, ee);
            check_val({tag, "/sat_over"}, overs, eo);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "/busy"}, {busy0, busys, busy1}, 3'b000);
        check_val({tag, "/s_ready"}, {s_ready0, s_readys, s_ready1}, 3'b000);
        check_val({tag, "/m_valid"}, {m_valid0, m_valids, m_valid1}, 3'b000);
        check_val({tag, "/sum"}, {sum0, 15'd0, sums, sum1}, 96'd0);
        check_val({tag, "/max"}, {max0, maxs, max1}, 48'd0);
        check_val({tag, "/err"}, {err0, errs, err1}, 48'd0);
        check_val({tag, "/over"}, {over0, overs, over1}, 48'd0);
    endtask

    // Offers the first n queued samples with random gaps; counts a sample only when the
    // handshake completes on the following edge.
    task automatic feed(input int sel, input int n, input bit mid_start);
        int  idx = 0;
        int  cyc = 0;
        logic rdy;
        while (idx < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            start = (mid_start && cyc == 3);
            if ($urandom_range(0, 3) != 0) begin
                s_valid     = 1'b1;
                op_a        = 8'(win_q[idx].a);
                op_b        = 8'(win_q[idx].b);
                approx_prod = 16'(win_q[idx].ap);
            end else begin
                s_valid     = 1'b0;
                op_a        = 8'($urandom);
                op_b        = 8'($urandom);
                approx_prod = 16'($urandom);
            end
            rdy = (sel == 1) ? s_ready1 : s_ready0;
            if (s_valid && rdy) idx++;
        end
        check_val("feed_done", idx, n);
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic run_win(input int sel, input bit bp, input bit mid_start, input string tag);
        int   cyc;
        logic mv;
        if (sel == 1) m_ready1 = !bp; else m_ready = !bp;
        @(negedge clk);
        if (sel == 1) start1 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start1 = 1'b0;
        if (sel == 1) check_val({tag, "/accum"}, {busy1, s_ready1}, 2'b11);
        else          check_val({tag, "/accum"}, {busy0, s_ready0, busys, s_readys}, 4'b1111);
        feed(sel, win_q.size(), mid_start);
        cyc = 0;
        mv  = (sel == 1) ? m_valid1 : m_valid0;
        while (!mv && cyc < 6) begin
            @(negedge clk);
            cyc++;
            mv = (sel == 1) ? m_valid1 : m_valid0;
        end
        check_val({tag, "/report_seen"}, mv, 1'b1);
        check_stats(sel, tag);
        if (bp) begin
            for (int i = 0; i < 20; i++) begin
                s_valid     = 1'b1;
                approx_prod = 16'($urandom);
                @(negedge clk);
                if (sel == 1) check_val({tag, "/bp_hold"}, {m_valid1, s_ready1}, 2'b10);
                else          check_val({tag, "/bp_hold"}, {m_valid0, s_ready0, m_valids}, 3'b101);
            end
            s_valid = 1'b0;
            check_stats(sel, {tag, "/bp"});
            if (sel == 1) m_ready1 = 1'b1; else m_ready = 1'b1;
        end
        @(negedge clk);
        if (sel == 1) check_val({tag, "/idle"}, {m_valid1, busy1}, 2'b00);
        else          check_val({tag, "/idle"}, {m_valid0, busy0, m_valids, busys}, 4'b0000);
        check_stats(sel, {tag, "/held"});
        m_ready  = 1'b0;
        m_ready1 = 1'b0;
    endtask

    function automatic int mk_ap(input int ex);
        int v;
        case ($urandom_range(0, 3))
            0: v = ex;
            1: v = ex + int'($urandom_range(0, 300));
            2: v = ex - int'($urandom_range(0, 300));
            default: v = int'($urandom_range(0, 65535));
        endcase
        if (v > 65535) v = 65535;
        if (v < 0) v = 0;
        return v;
    endfunction

    task automatic push(input int a, input int b, input int ap);
        smp_t s;
        s.a = a; s.b = b; s.ap = ap;
        win_q.push_back(s);
    endtask

    initial begin
        int a, b;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; s_valid = 1'b0;
        m_ready = 1'b0; m_ready1 = 1'b0; op_a = '0; op_b = '0; approx_prod = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_reset");

        // All exact products: nothing to report.
        win_q.delete();
        for (int i = 0; i < 4; i++) push(3, 5, 15);
        run_win(0, 0, 0, "exact");

        // Large errors, then two exact samples.
        win_q.delete();
        push(255, 255, 57600); push(200, 100, 19200); push(1, 1, 1); push(0, 0, 0);
        run_win(0, 0, 0, "large");

        // One over-estimate among exact samples, with report back-pressure.
        win_q.delete();
        push(10, 10, 112); push(3, 5, 15); push(7, 7, 49); push(2, 2, 4);
        run_win(0, 1, 0, "over_bp");

        // Maximal error distance saturates the 17-bit sum; start during ACCUM is ignored.
        win_q.delete();
        for (int i = 0; i < 4; i++) push(0, 0, 65535);
        run_win(0, 0, 1, "sat");

        // Reset after two samples discards them; the next window only sees new samples.
        win_q.delete();
        push(255, 255, 0); push(255, 255, 0); push(1, 1, 1); push(1, 1, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(0, 2, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_rst");
        win_q.delete();
        push(10, 10, 112); push(4, 4, 16); push(9, 9, 80); push(6, 6, 36);
        run_win(0, 0, 0, "after_rst");

        // Single-sample windows.
        win_q.delete();
        push(10, 10, 112);
        run_win(1, 0, 0, "w1_a");
        win_q.delete();
        push(255, 255, 57600);
        run_win(1, 1, 0, "w1_bp");

        // Random windows.
        for (int w = 0; w < 8; w++) begin
            win_q.delete();
            for (int i = 0; i < 4; i++) begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
                push(a, b, mk_ap(a * b));
            end
            run_win(0, (w % 3) == 0, (w % 4) == 1, "rand");
        end
        for (int w = 0; w < 4; w++) begin
            win_q.delete();
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            push(a, b, mk_ap(a * b));
            run_win(1, w[0], 0, "rand_w1");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
